// File: rtl/bus_merge_pkg.sv
// Shared constants and state encodings for the 12-bit bus merger.
package bus_merge_pkg;

  localparam int W1 = 8;        // low field y1 -> A[W1-1:0]
  localparam int W2 = 4;        // high field y2 -> A[W1+W2-1:W1]
  localparam int WA = W1 + W2;  // merged word width

  // Holding-register occupancy, encoded as {h2_full, h1_full}.
  localparam logic [1:0] ST_EMPTY     = 2'b00;
  localparam logic [1:0] ST_HAVE_Y1   = 2'b01;
  localparam logic [1:0] ST_HAVE_Y2   = 2'b10;
  localparam logic [1:0] ST_HAVE_BOTH = 2'b11;

  typedef enum logic [1:0] {
    EMPTY     = ST_EMPTY,
    HAVE_Y1   = ST_HAVE_Y1,
    HAVE_Y2   = ST_HAVE_Y2,
    HAVE_BOTH = ST_HAVE_BOTH
  } state_e;

endpackage

// File: rtl/bus_merge_if.sv
// Field-input and merged-output handshakes of bus_merge.
interface bus_merge_if;

  logic [bus_merge_pkg::W1-1:0] y1;
  logic                         y1_valid;
  logic                         y1_ready;
  logic [bus_merge_pkg::W2-1:0] y2;
  logic                         y2_valid;
  logic                         y2_ready;
  logic [bus_merge_pkg::WA-1:0] A;
  logic                         A_valid;
  logic                         A_ready;

  // Merger side: consumes fields, produces the merged word.
  modport slave (
    input  y1, y1_valid, y2, y2_valid, A_ready,
    output y1_ready, y2_ready, A, A_valid
  );

  // Environment side: field producers and word consumer.
  modport master (
    output y1, y1_valid, y2, y2_valid, A_ready,
    input  y1_ready, y2_ready, A, A_valid
  );

endinterface

// File: rtl/bus_merge_field_latch.sv
// One-entry holding register for a single field with a valid/ready input.
// Ready is the inverse of the full flag, so it never depends on an input.
module field_latch #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  input  logic         d_valid,
  output logic         d_ready,
  input  logic         clr,
  output logic [W-1:0] q,
  output logic         full
);

  logic [W-1:0] data_q;
  logic         full_q;

  // Capture a field when empty; release it when the merger takes it.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments in clocked blocks so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      // NOTE: the data register is cleared too, so a discarded partial
      // word can never leak into a later merge.
      data_q <= '0;
      full_q <= 1'b0;
    end else if (clr) begin
      full_q <= 1'b0;
    end else if (d_valid && !full_q) begin
      data_q <= d;
      full_q <= 1'b1;
    end
  end

  assign d_ready = !full_q;
  assign q       = data_q;
  assign full    = full_q;

endmodule

// File: rtl/bus_merge.sv
// Rebuilds a 12-bit word A = {y2, y1} from independently arriving fields
// and hands it to the consumer through a registered valid/ready output.
module bus_merge
  import bus_merge_pkg::*;
(
  input logic        clk,
  input logic        rst,
  bus_merge_if.slave bus
);

  logic [W1-1:0] h1_q;
  logic [W2-1:0] h2_q;
  logic          h1_full;
  logic          h2_full;
  state_e        state;
  logic          merge;

  logic [WA-1:0] a_q, a_d;
  logic          a_valid_q, a_valid_d;

  field_latch #(.W(W1)) u_lat_y1 (
    .clk     (clk),
    .rst     (rst),
    .d       (bus.y1),
    .d_valid (bus.y1_valid),
    .d_ready (bus.y1_ready),
    .clr     (merge),
    .q       (h1_q),
    .full    (h1_full)
  );

  field_latch #(.W(W2)) u_lat_y2 (
    .clk     (clk),
    .rst     (rst),
    .d       (bus.y2),
    .d_valid (bus.y2_valid),
    .d_ready (bus.y2_ready),
    .clr     (merge),
    .q       (h2_q),
    .full    (h2_full)
  );

  // Merge when both fields are held and the output slot is free or draining.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    a_d       = a_q;
    a_valid_d = a_valid_q;
    state     = state_e'({h2_full, h1_full});
    merge     = (state == HAVE_BOTH) && (!a_valid_q || bus.A_ready);
    if (merge) begin
      a_d       = {h2_q, h1_q};
      a_valid_d = 1'b1;
    end else if (a_valid_q && bus.A_ready) begin
      a_valid_d = 1'b0;
    end
  end

  // Output word register; A holds its value while backpressured.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= '0;
      a_valid_q <= 1'b0;
    end else begin
      a_q       <= a_d;
      a_valid_q <= a_valid_d;
    end
  end

  assign bus.A       = a_q;
  assign bus.A_valid = a_valid_q;

endmodule

// File: tb/tb_bus_merge.sv
// Directed self-checking bench for bus_merge.
module tb_bus_merge;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  bus_merge_if bus ();

  bus_merge dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle so outputs reflect that edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [7:0]  s_y1 [8];
  logic [3:0]  s_y2 [8];
  logic [11:0] s_a  [8];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    s_y1 = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
    s_y2 = '{4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h9, 4'h8};
    s_a  = '{12'hF01, 12'hE23, 12'hD45, 12'hC67, 12'hB89, 12'hAAB, 12'h9CD, 12'h8EF};

    rst = 1'b1;
    bus.y1 = '0; bus.y1_valid = 1'b0;
    bus.y2 = '0; bus.y2_valid = 1'b0;
    bus.A_ready = 1'b0;
    #1;
    step();
    step();
    rst = 1'b0;
    check("rst_A", 16'(bus.A), 16'h000);
    check("rst_A_valid", 16'(bus.A_valid), 16'h0);
    check("rst_y1_ready", 16'(bus.y1_ready), 16'h1);
    check("rst_y2_ready", 16'(bus.y2_ready), 16'h1);

    // 1: y1 then y2, merge one cycle after the second capture.
    bus.A_ready = 1'b1;
    bus.y1 = 8'hB6; bus.y1_valid = 1'b1;
    step();
    bus.y1_valid = 1'b0;
    check("t1_y1_ready_low", 16'(bus.y1_ready), 16'h0);
    check("t1_y2_ready_high", 16'(bus.y2_ready), 16'h1);
    bus.y2 = 4'h3; bus.y2_valid = 1'b1;
    step();
    bus.y2_valid = 1'b0;
    check("t1_no_valid_yet", 16'(bus.A_valid), 16'h0);
    step();
    check("t1_A", 16'(bus.A), 16'h3B6);
    check("t1_A_valid", 16'(bus.A_valid), 16'h1);
    check("t1_y1_ready_back", 16'(bus.y1_ready), 16'h1);
    step();
    check("t1_consumed", 16'(bus.A_valid), 16'h0);
    check("t1_A_hold", 16'(bus.A), 16'h3B6);

    // 2a: both fields in the same cycle.
    bus.y1 = 8'h05; bus.y1_valid = 1'b1;
    bus.y2 = 4'h0;  bus.y2_valid = 1'b1;
    step();
    bus.y1_valid = 1'b0; bus.y2_valid = 1'b0;
    step();
    check("t2a_A", 16'(bus.A), 16'h005);
    check("t2a_A_valid", 16'(bus.A_valid), 16'h1);
    step();
    // 2b: y2 first, then y1.
    bus.y2 = 4'h0; bus.y2_valid = 1'b1;
    step();
    bus.y2_valid = 1'b0;
    bus.y1 = 8'h05; bus.y1_valid = 1'b1;
    step();
    bus.y1_valid = 1'b0;
    check("t2b_wait", 16'(bus.A_valid), 16'h0);
    step();
    check("t2b_A", 16'(bus.A), 16'h005);
    check("t2b_A_valid", 16'(bus.A_valid), 16'h1);
    step();

    // 3: backpressure with a full pair waiting behind the held word.
    bus.A_ready = 1'b0;
    bus.y1 = 8'hB6; bus.y1_valid = 1'b1;
    bus.y2 = 4'h3;  bus.y2_valid = 1'b1;
    step();
    bus.y1_valid = 1'b0; bus.y2_valid = 1'b0;
    step();
    check("t3_A_first", 16'(bus.A), 16'h3B6);
    bus.y1 = 8'hFF; bus.y1_valid = 1'b1;
    bus.y2 = 4'hF;  bus.y2_valid = 1'b1;
    step();
    bus.y2_valid = 1'b0;
    bus.y1 = 8'h11;
    step();
    step();
    step();
    bus.y1_valid = 1'b0;
    check("t3_A_stable", 16'(bus.A), 16'h3B6);
    check("t3_A_valid_held", 16'(bus.A_valid), 16'h1);
    check("t3_y1_ready_low", 16'(bus.y1_ready), 16'h0);
    check("t3_y2_ready_low", 16'(bus.y2_ready), 16'h0);
    bus.A_ready = 1'b1;
    step();
    check("t3_A_next", 16'(bus.A), 16'hFFF);
    check("t3_no_bubble", 16'(bus.A_valid), 16'h1);
    step();
    check("t3_drained", 16'(bus.A_valid), 16'h0);

    // 4: reset discards a partially captured word.
    bus.y1 = 8'hAA; bus.y1_valid = 1'b1;
    step();
    bus.y1_valid = 1'b0;
    check("t4_partial", 16'(bus.y1_ready), 16'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t4_A", 16'(bus.A), 16'h000);
    check("t4_A_valid", 16'(bus.A_valid), 16'h0);
    check("t4_y1_ready", 16'(bus.y1_ready), 16'h1);
    bus.y2 = 4'h1; bus.y2_valid = 1'b1;
    step();
    bus.y2_valid = 1'b0;
    bus.y1 = 8'h22; bus.y1_valid = 1'b1;
    step();
    bus.y1_valid = 1'b0;
    step();
    check("t4_A_after", 16'(bus.A), 16'h122);
    check("t4_A_valid_after", 16'(bus.A_valid), 16'h1);
    step();

    // 5: streaming, one word every two cycles.
    bus.y1_valid = 1'b1; bus.y2_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.y1 = s_y1[i]; bus.y2 = s_y2[i];
      step();
      check($sformatf("t5_gap_%0d", i), 16'(bus.A_valid), 16'h0);
      step();
      check($sformatf("t5_A_%0d", i), 16'(bus.A), 16'(s_a[i]));
      check($sformatf("t5_valid_%0d", i), 16'(bus.A_valid), 16'h1);
    end
    bus.y1_valid = 1'b0; bus.y2_valid = 1'b0;
    step();
    check("t5_idle", 16'(bus.A_valid), 16'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
